// File: rtl/timer_pkg.sv
// Shared register offsets, CTRL bit positions, mode encodings and FSM states for mips_timer.
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;
  localparam int CTRL_PS_HI   = 7;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the count rate by 2^ps: tick is high one cycle in every 2^ps.
// Combinational tick from the divider register; clr restarts the divider from zero.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [3:0] ps,
  output logic       tick
);

  logic [15:0] div_cnt;
  logic [15:0] limit;

  assign limit = (16'd1 << ps) - 16'd1;
  assign tick  = (div_cnt == limit);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer: irq after PRESET+3 cycles from enable; one-shot (held) or auto-reload.
// TIMER_PRESCALE_EN adds CTRL[7:4] prescale, slowing the countdown by 2^PS; no bus backpressure.
module mips_timer
  import timer_pkg::*;
#(
  parameter int         CNT_W         = 32,
  parameter logic [1:0] IRQ_HOLD_MODE = MODE_ONESHOT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dev_addr,
  input  logic        dev_we,
  input  logic [31:0] dev_wdata,
  output logic [31:0] dev_rdata,
  output logic        irq
);

  state_t           state;
  logic             ctrl_en;
  logic             ctrl_im;
  logic [1:0]       ctrl_mode;
  logic [3:0]       ctrl_ps;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag;
  logic             tick;
  logic             reload;
  logic             wr_ctrl;
  logic             wr_preset;

  assign wr_ctrl   = dev_we && (dev_addr == ADDR_CTRL);
  assign wr_preset = dev_we && (dev_addr == ADDR_PRESET);
  // Only the reload encoding re-arms; every other mode holds the interrupt.
  assign reload    = (ctrl_mode == MODE_RELOAD) && (ctrl_mode != IRQ_HOLD_MODE);
  assign irq       = irq_flag & ctrl_im;

`ifdef TIMER_PRESCALE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_ps <= '0;
    end else if (wr_ctrl) begin
      ctrl_ps <= dev_wdata[CTRL_PS_HI:CTRL_PS_LO];
    end
  end

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == LOAD) || !ctrl_en),
    .ps    (ctrl_ps),
    .tick  (tick)
  );
`else
  assign ctrl_ps = 4'd0;
  assign tick    = 1'b1;
`endif

  always_comb begin
    dev_rdata = '0;
    case (dev_addr)
      ADDR_CTRL:   dev_rdata = {24'd0, ctrl_ps, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: dev_rdata = 32'(preset);
      ADDR_COUNT:  dev_rdata = 32'(count);
      default:     dev_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_im   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else begin
      // A bus write to CTRL overrides the FSM clearing EN on expiry.
      if (wr_ctrl) begin
        ctrl_en   <= dev_wdata[CTRL_EN];
        ctrl_mode <= dev_wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        ctrl_im   <= dev_wdata[CTRL_IM];
      end else if (state == INT && !reload) begin
        ctrl_en   <= 1'b0;
      end

      if (wr_preset) begin
        preset <= CNT_W'(dev_wdata);
      end

      // Setting on expiry beats the acknowledge so an interrupt is never dropped.
      if (state == INT) begin
        irq_flag <= 1'b1;
      end else if (wr_ctrl || wr_preset) begin
        irq_flag <= 1'b0;
      end else if (irq_flag && reload) begin
        irq_flag <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ctrl_en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= (preset == '0) ? INT : CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > CNT_W'(1)) begin
              count <= count - CNT_W'(1);
            end else begin
              count <= '0;
              state <= INT;
            end
          end
        end
        INT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_timer.sv
// Directed-plus-random bench for mips_timer; expected irq/COUNT derived from the enable-edge arithmetic.
module tb_mips_timer;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dev_addr;
  logic        dev_we;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mips_timer dut (
    .clk       (clk),
    .reset     (reset),
    .dev_addr  (dev_addr),
    .dev_we    (dev_we),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    dev_we    = 1'b1;
    dev_addr  = a;
    dev_wdata = d;
    @(posedge clk);
    #1;
    dev_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    dev_addr = a;
    #1;
    d = dev_rdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Expected COUNT e edges after the enabling write, one-shot mode.
  function automatic int exp_count(input int p, input int e);
    if (e < 2) return 0;
    return (p > e - 2) ? p - (e - 2) : 0;
  endfunction

  initial begin
    logic [31:0] v;
    logic [31:0] ps_bits;
    int p, per, pulses, f, frozen;

    reset     = 1'b0;
    dev_we    = 1'b0;
    dev_addr  = 2'd0;
    dev_wdata = '0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state and register map boundaries
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("rst_rdata", v, 32'd0);
    end
    wr(ADDR_CTRL, 32'hFFFF_FFF8);
    rd(ADDR_CTRL, v);
`ifdef TIMER_PRESCALE_EN
    ps_bits = 32'hF0;
`else
    ps_bits = 32'h00;
`endif
    chk("ctrl_mask", v, ps_bits | 32'h8);
    wr(ADDR_COUNT, 32'h1234);
    wr(2'd3, 32'h5678);
    rd(ADDR_COUNT, v);
    chk("count_ro", v, 32'd0);
    rd(2'd3, v);
    chk("reserved_rd", v, 32'd0);

    // One-shot countdown, directed PRESET=5 then random presets
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 5 : int'($urandom_range(0, 12));
      do_reset();
      wr(ADDR_PRESET, 32'(p));
      wr(ADDR_CTRL, 32'h9);
      for (int e = 1; e <= p + 6; e++) begin
        tick();
        chk("m0_irq", {31'd0, irq}, 32'(e >= p + 3));
        rd(ADDR_COUNT, v);
        if (e >= 2) chk("m0_count", v, 32'(exp_count(p, e)));
      end
      rd(ADDR_CTRL, v);
      chk("m0_ctrl_en_clr", v, 32'h8);
      wr(ADDR_CTRL, 32'h8);
      chk("m0_ack", {31'd0, irq}, 32'd0);
      tick();
      chk("m0_ack_hold", {31'd0, irq}, 32'd0);
    end

    // Auto-reload: period PRESET+3, COUNT sawtooth
    for (int it = 0; it < 2; it++) begin
      p = (it == 0) ? 3 : int'($urandom_range(1, 8));
      per = p + 3;
      pulses = 0;
      do_reset();
      wr(ADDR_PRESET, 32'(p));
      wr(ADDR_CTRL, 32'hB);
      for (int e = 1; e <= 3 * per + 3; e++) begin
        tick();
        chk("m1_irq", {31'd0, irq}, 32'((e >= per) && ((e - per) % per == 0)));
        if (irq) pulses++;
        rd(ADDR_COUNT, v);
        if (e >= 2) chk("m1_count", v, 32'((((e - 2) % per) <= p) ? p - ((e - 2) % per) : 0));
      end
      chk("m1_pulses", 32'(pulses >= 3), 32'd1);
    end

    // PRESET=0 expiry, and masked variant
    do_reset();
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h9);
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("p0_irq", {31'd0, irq}, 32'(e >= 3));
    end
    do_reset();
    wr(ADDR_PRESET, 32'd0);
    wr(ADDR_CTRL, 32'h1);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("im0_irq", {31'd0, irq}, 32'd0);
    end
    rd(ADDR_CTRL, v);
    chk("im0_ctrl", v, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    for (int e = 0; e < 3; e++) begin
      chk("im0_unmask", {31'd0, irq}, 32'd0);
      tick();
    end

    // PRESET rewrite mid-count leaves the running countdown alone
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    for (int e = 1; e <= 8; e++) tick();
    rd(ADDR_COUNT, v);
    chk("pw_count4", v, 32'd4);
    wr(ADDR_PRESET, 32'd2);
    rd(ADDR_PRESET, v);
    chk("pw_preset", v, 32'd2);
    for (int e = 10; e <= 15; e++) begin
      tick();
      chk("pw_irq", {31'd0, irq}, 32'(e >= 13));
      rd(ADDR_COUNT, v);
      chk("pw_count", v, 32'(exp_count(10, e)));
    end

    // Disable mid-count freezes COUNT
    f = int'($urandom_range(3, 11));
    frozen = 10 - (f - 2);
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    for (int e = 1; e < f; e++) tick();
    wr(ADDR_CTRL, 32'h0);
    for (int e = 0; e < 6; e++) begin
      tick();
      rd(ADDR_COUNT, v);
      chk("frz_count", v, 32'(frozen));
      chk("frz_irq", {31'd0, irq}, 32'd0);
    end

    // Reset mid-count aborts everything
    do_reset();
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    for (int e = 0; e < 5; e++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      chk("midrst_rdata", v, 32'd0);
    end
    for (int e = 0; e < 4; e++) tick();
    rd(ADDR_COUNT, v);
    chk("midrst_count", v, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);

    // CTRL write landing on the expiry edge: write wins, flag still set
    p = int'($urandom_range(0, 5));
    per = p + 3;
    do_reset();
    wr(ADDR_PRESET, 32'(p));
    wr(ADDR_CTRL, 32'h9);
    for (int e = 1; e <= p + 2; e++) tick();
    wr(ADDR_CTRL, 32'h9);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    rd(ADDR_CTRL, v);
    chk("coll_ctrl", v, 32'h9);
    for (int e = per + 1; e <= 2 * per; e++) begin
      tick();
      chk("coll_irq_hold", {31'd0, irq}, 32'd1);
      rd(ADDR_CTRL, v);
      chk("coll_ctrl_run", v, (e >= 2 * per) ? 32'h8 : 32'h9);
    end

`ifdef TIMER_PRESCALE_EN
    // Prescaled countdown: PS=2, PRESET=3 expires at 3 + 3*4 edges
    do_reset();
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h29);
    for (int e = 1; e <= 17; e++) begin
      tick();
      chk("ps_irq", {31'd0, irq}, 32'(e >= 15));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_timer.md
Name: mips_timer

Overview:
- Memory-mapped programmable countdown timer on the P7 system bridge, upstream of the CPU.
- Its `irq` output drives the CPU `interrupt` input and is routed into CP0's external-interrupt bit.
- Software programs it with `sw`/`lw` through the bridge.
- Interrupts come from counter expiry, not from a bench-forced pulse.

Parameters:
- CNT_W, 32, width of PRESET and COUNT registers.
- IRQ_HOLD_MODE, 0, mode encoding that holds the interrupt until acknowledged (one-shot). Mode 1 is auto-reload.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- dev_addr  in  2  word offset within device: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- dev_we  in  1  write strobe from bridge; full-word writes only.
- dev_wdata  in  32  write data.
- dev_rdata  out  32  combinational read data for dev_addr.
- irq  out  1  interrupt request to CPU/CP0.

Behaviour:
- Registers:
  - CTRL[0]=EN, CTRL[2:1]=MODE, CTRL[3]=IM (interrupt mask); other bits read 0.
  - PRESET is R/W.
  - COUNT is read-only; writes to offsets 2 and 3 are ignored.
- Reset (reset==0 at a rising edge): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Therefore irq=0 and dev_rdata reflects zeros. Reset mid-count aborts immediately.
- Output: irq = irq_flag & CTRL.IM, combinational from registers.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET. If PRESET==0 go to INT, else go to CNT.
  - CNT: if EN==0, go to IDLE (COUNT holds). Else if COUNT>1, decrement. Else COUNT<=0 and go to INT.
  - INT: irq_flag<=1, then go to IDLE.
    - MODE 0: EN<=0.
    - MODE 1: EN kept; irq_flag auto-clears on the next edge (one-cycle pulse); re-enters LOAD.
    - MODE 2/3: treated as MODE 0.
- Latency: CTRL written with EN=1 at edge N → COUNT=PRESET after N+2 → irq high after edge N+3+PRESET (PRESET=0 gives N+3).
- Auto-reload period: PRESET+3 cycles.
- Acknowledge (MODE 0): any write to CTRL or PRESET clears irq_flag.
- PRESET write while in CNT does not affect the running COUNT; it takes effect at the next LOAD.
- Simultaneous events:
  - Bus write to CTRL in the same cycle FSM clears EN in INT: the written CTRL value wins.
  - irq_flag set by INT wins over the write-clear; the interrupt is never lost.
- Arithmetic: COUNT is unsigned, never wraps below 0.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - CTRL[7:4]=PS is R/W.
  - In CNT, COUNT decrements once every 2^PS cycles.
  - The prescale counter clears in LOAD and whenever EN==0.
  - Latency becomes N+3+PRESET*2^PS.
- Undefined: CTRL[7:4] reads 0, writes ignored, decrement every cycle.

Decomposition:
- Package timer_pkg:
  - offset constants ADDR_CTRL/ADDR_PRESET/ADDR_COUNT.
  - CTRL bit indices.
  - mode encodings MODE_ONESHOT/MODE_RELOAD.
  - state enum {IDLE,LOAD,CNT,INT}.
- One sub-module, timer_prescaler, only instantiated under TIMER_PRESCALE_EN.
  - Inputs: clk, reset, clr, ps.
  - Output: tick.

Test Plan:
- Reset held low 2 cycles, then PRESET=5, CTRL=0x9 (EN, IM, mode 0) → irq rises after edge N+8; COUNT reads 0; CTRL reads 0x8; irq stays high until CTRL write 0x8 → irq 0 next cycle.
- PRESET=3, CTRL=0xB (mode 1) → irq one-cycle pulses every 6 cycles, at least 3 pulses; COUNT sequence 3,2,1,0 repeats.
- PRESET=0, CTRL=0x9 → irq after edge N+3; IM=0 variant (CTRL=0x1) → irq stays 0 while internal flag is set; later CTRL=0x8 write does not raise irq.
- Mode 0, PRESET=10; at COUNT=4 write PRESET=2 → expiry still at original time; write CTRL=0x0 mid-count → COUNT frozen, no irq; reset low mid-count → all registers 0.
- Same-cycle CTRL write (0x9) on the INT edge → irq_flag set and CTRL reads 0x9. With TIMER_PRESCALE_EN: PS=2, PRESET=3 → irq after N+15.
